// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream mux arbiter.
// Holds the mode encodings and the channel-index width helper.
package stream_mux_pkg;

    localparam logic [1:0] MODE_MANUAL = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b01;
    localparam logic [1:0] MODE_RR     = 2'b10;

    function automatic int ch_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Stream bundle between the arbiter mux and its producers/consumer.
// The master view is the mux; the slave view is the surrounding logic.
interface stream_mux_arb_if
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 2
);
    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;

    modport master (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_ch
    );

    modport slave (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Grant generation for manual, fixed-priority and round-robin modes.
// The round-robin pointer only moves on accepted transfers in RR mode.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         req,
    input  logic [1:0]                mode,
    input  logic [ch_w(NUM_CH)-1:0]   sel,
    input  logic                      advance,
    output logic [NUM_CH-1:0]         grant
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam logic [CH_W-1:0] PTR_RST = CH_W'(NUM_CH - 1);

    logic [CH_W-1:0] ptr;
    logic [CH_W-1:0] idx;
    logic [CH_W-1:0] win;
    logic            found;
    logic            rr_mode;

    assign rr_mode = (mode & MODE_RR) != 2'b00;

    always_comb begin
        grant = '0;
        win   = ptr;
        idx   = '0;
        found = 1'b0;
        unique case (1'b1)
            mode == MODE_MANUAL: begin
                if (int'(sel) < NUM_CH && req[sel]) begin
                    grant[sel] = 1'b1;
                end
            end
            mode == MODE_FIXED: begin
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        grant    = '0;
                        grant[i] = 1'b1;
                    end
                end
            end
            default: begin
                // search starts just past the last winner and wraps
                for (int k = 1; k <= NUM_CH; k++) begin
                    idx = CH_W'((int'(ptr) + k) % NUM_CH);
                    if (!found && req[idx]) begin
                        grant[idx] = 1'b1;
                        win        = idx;
                        found      = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PTR_RST;
        end else if (advance && rr_mode) begin
            ptr <= win;
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel stream multiplexer with a one-word registered output.
// Arbitration lives in rr_arbiter; this level owns the output slot.
module stream_mux_arb
    import stream_mux_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_CH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic [ch_w(NUM_CH)-1:0] sel,
    stream_mux_arb_if.master        bus
);
    localparam int CH_W = ch_w(NUM_CH);

    logic                load_en;
    logic                advance;
    logic [NUM_CH-1:0]   grant;
    logic [WIDTH-1:0]    pick_data;
    logic [CH_W-1:0]     pick_ch;
    logic [WIDTH-1:0]    data_q;
    logic [CH_W-1:0]     ch_q;
    logic                valid_q;

    assign load_en      = (!valid_q | bus.out_ready) & !reset;
    assign advance      = load_en & (|grant);
    assign bus.in_ready = {NUM_CH{load_en}} & grant;

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.in_valid),
        .mode    (mode),
        .sel     (sel),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        pick_data = '0;
        pick_ch   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                pick_data = bus.in_data[i*WIDTH +: WIDTH];
                pick_ch   = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ch_q    <= '0;
        end else if (load_en) begin
            valid_q <= |grant;
            if (|grant) begin
                data_q <= pick_data;
                ch_q   <= pick_ch;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench for stream_mux_arb at NUM_CH = 2, 3 and 4.
module tb_stream_mux_arb;

    logic       clk;
    logic       reset;
    logic [1:0] mode2, mode3, mode4;
    logic [0:0] sel2;
    logic [1:0] sel3, sel4;

    int checks;
    int errors;

    stream_mux_arb_if #(.WIDTH(4), .NUM_CH(2)) b2 ();
    stream_mux_arb_if #(.WIDTH(4), .NUM_CH(3)) b3 ();
    stream_mux_arb_if #(.WIDTH(4), .NUM_CH(4)) b4 ();

    stream_mux_arb #(.WIDTH(4), .NUM_CH(2)) u2 (
        .clk   (clk),
        .reset (reset),
        .mode  (mode2),
        .sel   (sel2),
        .bus   (b2.master)
    );

    stream_mux_arb #(.WIDTH(4), .NUM_CH(3)) u3 (
        .clk   (clk),
        .reset (reset),
        .mode  (mode3),
        .sel   (sel3),
        .bus   (b3.master)
    );

    stream_mux_arb #(.WIDTH(4), .NUM_CH(4)) u4 (
        .clk   (clk),
        .reset (reset),
        .mode  (mode4),
        .sel   (sel4),
        .bus   (b4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        mode2 = 2'b00; mode3 = 2'b00; mode4 = 2'b00;
        sel2 = 1'b0; sel3 = 2'd0; sel4 = 2'd0;
        b2.in_valid = '0; b2.in_data = '0; b2.out_ready = 1'b0;
        b3.in_valid = '0; b3.in_data = '0; b3.out_ready = 1'b0;
        b4.in_valid = '0; b4.in_data = '0; b4.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;

        check("rst_valid2", b2.out_valid, 0);
        check("rst_valid4", b4.out_valid, 0);
        check("rst_data4", b4.out_data, 0);
        check("rst_ch4", b4.out_ch, 0);
        check("idle_ready4", b4.in_ready, 0);

        // manual select of channel 1 on the 2-channel mux
        mode2 = 2'b00;
        sel2 = 1'b1;
        b2.in_valid = 2'b11;
        b2.in_data = 8'hA5;
        b2.out_ready = 1'b1;
        #1;
        check("man_ready", b2.in_ready, 2'b10);
        tick();
        check("man_valid", b2.out_valid, 1);
        check("man_data", b2.out_data, 4'hA);
        check("man_ch", b2.out_ch, 1);
        b2.in_valid = 2'b00;
        tick();
        check("drain_valid", b2.out_valid, 0);

        // round-robin over four always-valid channels
        b4.in_data = 16'hBA98;
        b4.in_valid = 4'hF;
        b4.out_ready = 1'b1;
        mode4 = 2'b10;
        #1;
        check("rr_first", b4.in_ready, 4'b0001);
        for (int c = 0; c < 8; c++) begin
            tick();
            check("rr_valid", b4.out_valid, 1);
            check("rr_ch", b4.out_ch, c % 4);
            check("rr_data", b4.out_data, 8 + (c % 4));
            check("rr_ready", b4.in_ready, 1 << ((c + 1) % 4));
        end

        // fixed priority: ch1 always beats ch2, pointer stays at 3
        mode4 = 2'b01;
        b4.in_valid = 4'b0110;
        #1;
        check("fix_ready", b4.in_ready, 4'b0010);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("fix_ch", b4.out_ch, 1);
            check("fix_data", b4.out_data, 4'h9);
            check("fix_ready_hold", b4.in_ready, 4'b0010);
        end
        mode4 = 2'b10;
        b4.in_valid = 4'hF;
        #1;
        check("ptr_hold", b4.in_ready, 4'b0001);
        tick();
        check("ptr_ch", b4.out_ch, 0);
        check("ptr_data", b4.out_data, 4'h8);

        // back-pressure with churning inputs
        b4.out_ready = 1'b0;
        #1;
        check("bp_ready0", b4.in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            b4.in_valid = 4'hF ^ 4'(k);
            b4.in_data = 16'h1234 + 16'(k);
            mode4 = 2'(k);
            sel4 = 2'(k);
            #1;
            check("bp_ready", b4.in_ready, 0);
            tick();
            check("bp_valid", b4.out_valid, 1);
            check("bp_data", b4.out_data, 4'h8);
            check("bp_ch", b4.out_ch, 0);
        end

        // reset while a word is held discards it and re-arms ptr
        mode4 = 2'b10;
        b4.in_valid = 4'hF;
        b4.in_data = 16'hBA98;
        reset = 1'b1;
        #1;
        check("rst_ready", b4.in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst2_valid", b4.out_valid, 0);
        check("rst2_data", b4.out_data, 0);
        check("rst2_ch", b4.out_ch, 0);
        check("rst2_ready", b4.in_ready, 4'b0001);
        tick();
        check("rst2_first_ch", b4.out_ch, 0);
        check("rst2_first_data", b4.out_data, 4'h8);
        check("rst2_first_valid", b4.out_valid, 1);

        // manual select beyond NUM_CH grants nothing
        mode3 = 2'b00;
        sel3 = 2'd3;
        b3.in_valid = 3'b111;
        b3.in_data = 12'h765;
        b3.out_ready = 1'b1;
        #1;
        check("oor_ready", b3.in_ready, 0);
        tick();
        check("oor_valid1", b3.out_valid, 0);
        tick();
        check("oor_valid2", b3.out_valid, 0);
        sel3 = 2'd2;
        #1;
        check("sel2_ready", b3.in_ready, 3'b100);
        tick();
        check("sel2_valid", b3.out_valid, 1);
        check("sel2_ch", b3.out_ch, 2);
        check("sel2_data", b3.out_data, 4'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
